// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serial_state_e;

  // Level the line rests at between frames; the start bit is its complement.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: tick marks the last clock of every BIT_CYCLES-long bit period.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-BIT_CYCLES counter, realigned to zero when a frame starts.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             tx,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  serial_state_e    state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shreg_sh;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             tx_nxt, ready_nxt, done_nxt;
  logic             clear, tick;

  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // that tx/ready/done come straight from flops.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx;
    ready_nxt   = 1'b0;
    done_nxt    = 1'b0;
    clear       = 1'b0;
    shreg_sh    = shreg >> 1;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        tx_nxt    = LINE_IDLE;
        if (load) begin
          state_nxt = START;
          shreg_nxt = data_in;
          tx_nxt    = ~LINE_IDLE;
          ready_nxt = 1'b0;
          clear     = 1'b1;
        end
      end
      START: begin
        tx_nxt = ~LINE_IDLE;
        if (tick) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          tx_nxt      = shreg[0];
        end
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (tick) begin
          if (bit_cnt == BIT_LAST) begin
            state_nxt = STOP;
            tx_nxt    = LINE_IDLE;
          end else begin
            shreg_nxt   = shreg_sh;
            bit_cnt_nxt = bit_cnt + BW'(1);
            tx_nxt      = shreg_sh[0];
          end
        end
      end
      STOP: begin
        tx_nxt = LINE_IDLE;
        if (tick) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = LINE_IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= LINE_IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx      <= tx_nxt;
      ready   <= ready_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: 8-bit/4-cycle instance and 4-bit/1-cycle instance.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst_a, load_a, ready_a, tx_a, done_a;
  logic [7:0] data_a;
  logic       rst_b, load_b, ready_b, tx_b, done_b;
  logic [3:0] data_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst_a), .data_in(data_a), .load(load_a),
    .ready(ready_a), .tx(tx_a), .done(done_a)
  );

  serial_tx #(.WIDTH(4), .BIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_b), .data_in(data_b), .load(load_b),
    .ready(ready_b), .tx(tx_b), .done(done_b)
  );

  // Expected line level j cycles after the load edge: frame = {stop, data, start}.
  function automatic logic exp_tx(input logic [31:0] d, input int w, input int bc, input int j);
    int idx;
    idx = j / bc;
    if (idx == 0) return 1'b0;
    else if (idx <= w) return d[idx-1];
    else return 1'b1;
  endfunction

  // Send one frame on dut_a; optionally disturb data_in and pulse load while busy.
  task automatic frame_a(input logic [7:0] d, input bit disturb);
    load_a = 1'b1;
    data_a = d;
    @(posedge clk); #1;
    load_a = 1'b0;
    for (int j = 0; j < 40; j++) begin
      checks++;
      if (tx_a !== exp_tx({24'd0, d}, 8, 4, j)) begin
        failures++;
        $display("FAIL frame_a_tx data=%h cycle=%0d tx=%b expected=%b", d, j, tx_a, exp_tx({24'd0, d}, 8, 4, j));
      end
      checks++;
      if (ready_a !== 1'b0 || done_a !== 1'b0) begin
        failures++;
        $display("FAIL frame_a_busy data=%h cycle=%0d ready=%b done=%b expected ready=0 done=0", d, j, ready_a, done_a);
      end
      if (disturb) begin
        data_a = (j == 10) ? 8'hFF : 8'($urandom);
        load_a = (j == 10);
      end
      @(posedge clk); #1;
    end
    load_a = 1'b0;
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b1 || tx_a !== 1'b1) begin
      failures++;
      $display("FAIL frame_a_done data=%h ready=%b done=%b tx=%b expected 1 1 1", d, ready_a, done_a, tx_a);
    end
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_a !== 1'b1 || tx_a !== 1'b1 || done_a !== 1'b0) begin
        failures++;
        $display("FAIL idle_a cycle=%0d ready=%b tx=%b done=%b expected 1 1 0", i, ready_a, tx_a, done_a);
      end
    end
  endtask

  task automatic frame_b(input logic [3:0] d);
    load_b = 1'b1;
    data_b = d;
    @(posedge clk); #1;
    load_b = 1'b0;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (tx_b !== exp_tx({28'd0, d}, 4, 1, j) || ready_b !== 1'b0 || done_b !== 1'b0) begin
        failures++;
        $display("FAIL frame_b data=%h cycle=%0d tx=%b ready=%b done=%b expected tx=%b ready=0 done=0",
                 d, j, tx_b, ready_b, done_b, exp_tx({28'd0, d}, 4, 1, j));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ready_b !== 1'b1 || done_b !== 1'b1 || tx_b !== 1'b1) begin
      failures++;
      $display("FAIL frame_b_done data=%h ready=%b done=%b tx=%b expected 1 1 1", d, ready_b, done_b, tx_b);
    end
  endtask

  task automatic idle_b(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_b !== 1'b1 || tx_b !== 1'b1 || done_b !== 1'b0) begin
        failures++;
        $display("FAIL idle_b cycle=%0d ready=%b tx=%b done=%b expected 1 1 0", i, ready_b, tx_b, done_b);
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; load_a = 1'b1; data_a = 8'($urandom);
    rst_b = 1'b1; load_b = 1'b1; data_b = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || done_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_a cycle=%0d tx=%b ready=%b done=%b expected 1 1 0", i, tx_a, ready_a, done_a);
      end
      checks++;
      if (tx_b !== 1'b1 || ready_b !== 1'b1 || done_b !== 1'b0) begin
        failures++;
        $display("FAIL reset_b cycle=%0d tx=%b ready=%b done=%b expected 1 1 0", i, tx_b, ready_b, done_b);
      end
    end
    rst_a = 1'b0; load_a = 1'b0;
    rst_b = 1'b0; load_b = 1'b0;
    idle_a(4);
    idle_b(2);
  endtask

  task automatic test_single();
    frame_a(8'hA5, 1'b0);
    idle_a(2);
    for (int i = 0; i < 4; i++) begin
      frame_a(8'($urandom), 1'b0);
      idle_a(1);
    end
  endtask

  task automatic test_back_to_back();
    frame_a(8'h00, 1'b0);
    frame_a(8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) frame_a(8'($urandom), 1'b0);
    idle_a(2);
  endtask

  task automatic test_busy_load();
    frame_a(8'h3C, 1'b1);
    idle_a(3);
  endtask

  task automatic test_mid_reset();
    load_a = 1'b1;
    data_a = 8'h55;
    @(posedge clk); #1;
    load_a = 1'b0;
    for (int j = 0; j < 15; j++) begin
      checks++;
      if (tx_a !== exp_tx({24'd0, 8'h55}, 8, 4, j)) begin
        failures++;
        $display("FAIL mid_reset_tx cycle=%0d tx=%b expected=%b", j, tx_a, exp_tx({24'd0, 8'h55}, 8, 4, j));
      end
      @(posedge clk); #1;
    end
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    checks++;
    if (tx_a !== 1'b1 || ready_a !== 1'b1 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_abort tx=%b ready=%b done=%b expected 1 1 0", tx_a, ready_a, done_a);
    end
    idle_a(30);
    frame_a(8'h81, 1'b0);
    idle_a(1);
  endtask

  task automatic test_bit_cycles_one();
    frame_b(4'b1010);
    idle_b(1);
    for (int i = 0; i < 3; i++) frame_b(4'($urandom));
    idle_b(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_load();
    test_mid_reset();
    test_bit_cycles_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-in, serial-out frame transmitter. Accepts a WIDTH-bit word through a load/ready handshake and shifts it out on a single registered line: start bit (0), data LSB first, stop bit (1). Each bit is held for BIT_CYCLES clocks. It is the sending end of the team's single-wire serial link and is built from registered D-type storage in the same style as the existing flip-flop primitives.

Parameters:
WIDTH, 8, data word width in bits (>=1)
BIT_CYCLES, 4, clock cycles each serial bit is held on tx (>=1)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
data_in  input  WIDTH  word to transmit; sampled only on an accepted load
load  input  1  request to send data_in
ready  output  1  high when idle and able to accept load
tx  output  1  serial line, registered; idles high
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst. On a posedge with rst=1: state=IDLE, tx=1, ready=1, done=0, shift register and counters cleared. rst has priority over load.
- States: IDLE, START, DATA, STOP.
- IDLE: ready=1, tx=1. If load=1 at posedge k, data_in is captured into the shift register, state=START, ready=0, and tx=0 from edge k.
- START: tx=0 for BIT_CYCLES cycles, then DATA with bit index 0.
- DATA: tx=shreg[0] for BIT_CYCLES cycles per bit. Shift right after each bit. After bit WIDTH-1, go to STOP.
- STOP: tx=1 for BIT_CYCLES cycles. The edge ending STOP returns to IDLE with ready=1 and done=1 for exactly one cycle.
- Frame length: (WIDTH+2)*BIT_CYCLES cycles. Load accepted at edge k gives ready=1 and done=1 after edge k+(WIDTH+2)*BIT_CYCLES.
- Back-to-back: load=1 in the cycle done/ready is high is accepted. The next start bit begins immediately with no idle gap, and done still pulses.
- load while ready=0 is ignored. data_in changes during a frame have no effect.
- Reset mid-frame abandons the frame. tx goes to 1 on that edge, and no done pulse is generated.
- Counters: cycle counter of width max(1,$clog2(BIT_CYCLES)) counts 0..BIT_CYCLES-1 and wraps. Bit counter of width max(1,$clog2(WIDTH)) counts 0..WIDTH-1.
- BIT_CYCLES=1 must work: each bit lasts one clock.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package serial_pkg: state enumeration (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3) and the idle-line level constant LINE_IDLE=1'b1. The future serial_rx reuses both.
- One sub-module, bit_timer: parameter BIT_CYCLES; inputs clk, rst, clear; output tick, which is high on the last cycle of each bit period. The FSM advances only on tick and asserts clear on frame start.

Test Plan:
- Reset: hold rst=1 for 3 cycles with load=1 -> tx=1, ready=1, done=0 throughout. No frame starts after rst falls until load is reasserted.
- Single frame, WIDTH=8, BIT_CYCLES=4, data_in=8'hA5, load for 1 cycle -> tx over 40 cycles is 4x each of 0,1,0,1,0,0,1,0,1,1. ready=0 for those 40 cycles. done=1 on cycle 41 only.
- Back-to-back: send 8'h00, then load 8'hFF on the done cycle -> continuous 80-cycle stream: 0 x4, 0 x32, 1 x4, 0 x4, 1 x32, 1 x4. done pulses twice, 40 cycles apart.
- Busy load: send 8'h3C, pulse load with data_in=8'hFF at cycle 10 -> transmitted bits remain 0,0,1,1,1,1,0,0 (LSB first). Only one done pulse.
- Mid-frame reset: assert rst at cycle 15 of an 8'h55 frame -> tx=1 and ready=1 on the next edge, no done pulse. A new load of 8'h81 then transmits correctly.
- BIT_CYCLES=1, WIDTH=4, data_in=4'b1010 -> tx sequence 0,0,1,0,1,1 in consecutive cycles. done occurs 6 cycles after the load edge.
